regfile_write_sched: RTL and testbench
======================================

// Module: regfile_write_sched
// PURPOSE
//  Owns the single write port of register_file and shares it between two
//  requesters: req0, the debounced switch path, and req1, an auxiliary
//  loader. After every reset it first runs a clear sequence that writes
//  INIT_VAL to every register. It then grants the port round-robin, at most
//  one write per clock. All outputs are registered and drive the register_file
//  W / W_Adr / we inputs directly.
// PARAMETERS
//  DATA_W    16       width of write data
//  ADR_W     3        width of register address
//  NREG      8        registers cleared by the init sequence (<= 2**ADR_W)
//  INIT_VAL  16'h0000 value written to each register during init
// PORTS
//  clk        in   1       system clock, all logic on rising edge
//  reset      in   1       synchronous, active-high reset
//  req0       in   1       requester 0 write request (level)
//  adr0       in   ADR_W   requester 0 target address
//  data0      in   DATA_W  requester 0 write data
//  gnt0       out  1       requester 0 grant, 1-cycle pulse
//  req1       in   1       requester 1 write request (level)
//  adr1       in   ADR_W   requester 1 target address
//  data1      in   DATA_W  requester 1 write data
//  gnt1       out  1       requester 1 grant, 1-cycle pulse
//  rf_we      out  1       register_file write enable
//  rf_w_adr   out  ADR_W   register_file write address
//  rf_W       out  DATA_W  register_file write data
//  init_busy  out  1       high while the clear sequence runs
// BEHAVIOUR
//  Reset: state=INIT, cnt=0, rr_ptr=0, rf_we=0, rf_w_adr=0, rf_W=0,
//   gnt0=gnt1=0, init_busy=1. Reset wins over all other inputs in any state.
//   Reset asserted mid-init or mid-run restarts the init sequence from reg 0.
//  INIT: on each edge with reset low: rf_we<=1, rf_w_adr<=cnt, rf_W<=INIT_VAL,
//   cnt<=cnt+1. The edge that issues cnt=NREG-1 also moves state to RUN.
//   The first clear write is visible in the cycle after reset drops.
//   NREG write cycles in total, addresses 0..NREG-1 in order.
//   init_busy stays 1 through the cycle carrying the last clear write and
//   falls on the next edge. req0/req1 are ignored in INIT; gnt stays 0.
//  RUN, each edge:
//   - eligible_i = req_i & ~gnt_i: a requester whose gnt is high this cycle
//     is not eligible, so one held req never produces two writes.
//   - No eligible requester: rf_we<=0, gnt0/1<=0; rf_w_adr/rf_W hold.
//   - One eligible requester: it wins.
//   - Both eligible: the winner is rr_ptr (0 -> req0, 1 -> req1).
//   - On a win: rf_we<=1, rf_w_adr<=adr_w, rf_W<=data_w, gnt_w<=1,
//     other gnt<=0, rr_ptr<=~w.
//  Handshake: the requester holds adr/data stable while req is high. gnt_i
//   is high in exactly the cycle its write is on rf_*. The requester may
//   keep req high after gnt with new adr/data; this counts as a new request,
//   eligible one cycle after the gnt cycle. A single requester therefore
//   gets at most one write every 2 cycles. Two requesters alternate and
//   give one write per cycle.
//  Latency: req sampled at edge N -> rf_we and gnt high in cycle N..N+1.
//  Widths: adr/data pass through unmodified. cnt is ADR_W+1 bits so that
//   NREG = 2**ADR_W terminates without wrapping.
//  gnt0 and gnt1 are never high together. rf_we=1 implies exactly one gnt
//   is high in RUN, or init_busy=1.
// TESTING
//  1 Reset 2 cycles, then release -> rf_we=1 on 8 consecutive cycles with
//    adr 0..7, rf_W=0000; init_busy falls on the 9th edge; no gnt pulses.
//  2 After init, req0 only (adr=3, data=00A5) held 6 cycles -> gnt0 and
//    writes in alternating cycles (3 writes); rf_w_adr=3, rf_W=00A5 each time.
//  3 req0 and req1 both held (adr 1/2, data 1111/2222) -> writes alternate
//    0,1,0,1 starting with req0 (rr_ptr=0), one write per cycle, never both gnt.
//  4 req1 asserted during INIT -> no gnt1 until RUN; first RUN edge grants
//    req1 with its adr/data.
//  5 reset pulsed at the 4th init write -> sequence restarts at adr 0 and
//    runs 8 full writes.
//  6 reset pulsed while req0 and req1 are active in RUN -> gnt/rf_we drop
//    next edge, full init repeats, then arbitration restarts with req0 first.

Source files
------------

// File: rtl/regfile_write_sched_if.sv
// Write-port bundle between the requesters and the register_file
// scheduler.
interface regfile_write_sched_if #(
  parameter int DATA_W = 16,
  parameter int ADR_W  = 3
);
  logic              req0;
  logic [ADR_W-1:0]  adr0;
  logic [DATA_W-1:0] data0;
  logic              gnt0;
  logic              req1;
  logic [ADR_W-1:0]  adr1;
  logic [DATA_W-1:0] data1;
  logic              gnt1;
  logic              rf_we;
  logic [ADR_W-1:0]  rf_w_adr;
  logic [DATA_W-1:0] rf_W;
  logic              init_busy;

  modport master (
    output req0, adr0, data0,
    output req1, adr1, data1,
    input  gnt0, gnt1,
    input  rf_we, rf_w_adr, rf_W,
    input  init_busy
  );

  modport slave (
    input  req0, adr0, data0,
    input  req1, adr1, data1,
    output gnt0, gnt1,
    output rf_we, rf_w_adr, rf_W,
    output init_busy
  );
endinterface

// File: rtl/regfile_write_sched.sv
// Clears the register file after reset, then shares its single
// write port between two requesters round-robin.
module regfile_write_sched #(
  parameter int              DATA_W   = 16,
  parameter int              ADR_W    = 3,
  parameter int              NREG     = 8,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input logic                clk,
  input logic                reset,
  regfile_write_sched_if.slave bus
);

  localparam int CW = ADR_W + 1;
  localparam logic [CW-1:0] LAST = CW'(NREG - 1);

  typedef enum logic {
    S_INIT,
    S_RUN
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              rr_q, rr_d;
  logic              we_q, we_d;
  logic [ADR_W-1:0]  adr_q, adr_d;
  logic [DATA_W-1:0] w_q, w_d;
  logic              gnt0_q, gnt0_d;
  logic              gnt1_q, gnt1_d;
  logic              busy_q, busy_d;

  logic elig0, elig1;
  logic win0, win1;

  // A requester granted this cycle sits out one edge,
  // so a held req never yields two writes.
  assign elig0 = bus.req0 & ~gnt0_q;
  assign elig1 = bus.req1 & ~gnt1_q;
  assign win0  = elig0 & (~elig1 | ~rr_q);
  assign win1  = elig1 & (~elig0 |  rr_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_INIT;
      cnt_q   <= '0;
      rr_q    <= 1'b0;
      we_q    <= 1'b0;
      adr_q   <= '0;
      w_q     <= '0;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rr_q    <= rr_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      w_q     <= w_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rr_d    = rr_q;
    we_d    = 1'b0;
    adr_d   = adr_q;
    w_d     = w_q;
    gnt0_d  = 1'b0;
    gnt1_d  = 1'b0;
    busy_d  = 1'b0;
    unique case (state_q)
      S_INIT: begin
        we_d   = 1'b1;
        adr_d  = cnt_q[ADR_W-1:0];
        w_d    = INIT_VAL;
        cnt_d  = cnt_q + CW'(1);
        busy_d = 1'b1;
        if (cnt_q == LAST) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        unique case (1'b1)
          win0: begin
            we_d   = 1'b1;
            adr_d  = bus.adr0;
            w_d    = bus.data0;
            gnt0_d = 1'b1;
            rr_d   = 1'b1;
          end
          win1: begin
            we_d   = 1'b1;
            adr_d  = bus.adr1;
            w_d    = bus.data1;
            gnt1_d = 1'b1;
            rr_d   = 1'b0;
          end
          default: begin
          end
        endcase
      end
      default: begin
        state_d = S_INIT;
      end
    endcase
  end

  assign bus.rf_we     = we_q;
  assign bus.rf_w_adr  = adr_q;
  assign bus.rf_W      = w_q;
  assign bus.gnt0      = gnt0_q;
  assign bus.gnt1      = gnt1_q;
  assign bus.init_busy = busy_q;

  a_gnt_excl: assert property (
    @(posedge clk) disable iff (reset)
    !(gnt0_q && gnt1_q)
  );

  a_we_owner: assert property (
    @(posedge clk) disable iff (reset)
    we_q |-> (busy_q || (gnt0_q ^ gnt1_q))
  );

endmodule

// File: tb/tb_regfile_write_sched.sv
// Scoreboard bench for regfile_write_sched: init clear,
// round-robin grants and reset restarts.
`timescale 1ns/1ps
module tb_regfile_write_sched;

  typedef struct packed {
    logic [2:0]  adr;
    logic [15:0] data;
    logic [1:0]  src;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic mon_en = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  regfile_write_sched_if #(.DATA_W(16), .ADR_W(3)) bus ();

  regfile_write_sched #(
    .DATA_W(16), .ADR_W(3), .NREG(8), .INIT_VAL(16'h0000)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [2:0] a,
                      input logic [15:0] d,
                      input logic [1:0] s);
    exp_t e;
    e.adr = a; e.data = d; e.src = s;
    sb.push_back(e);
  endtask

  task automatic push_init;
    for (int i = 0; i < 8; i++) push(3'(i), 16'h0000, 2'd2);
  endtask

  task automatic run_init;
    reset = 1'b1;
    tick;
    push_init;
    reset = 1'b0;
    repeat (9) tick;
  endtask

  // Monitor: every rf write is popped from the scoreboard.
  always @(posedge clk) begin
    exp_t e;
    #2;
    if (mon_en) begin
      n_tests++;
      if (bus.gnt0 === 1'b1 && bus.gnt1 === 1'b1) begin
        n_fail++;
        $display("FAIL gnt_both: gnt0=%b gnt1=%b required not both",
                 bus.gnt0, bus.gnt1);
      end
      if (bus.rf_we === 1'b1) begin
        n_tests++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_write: adr=%0d W=%h, none required",
                   bus.rf_w_adr, bus.rf_W);
        end else begin
          e = sb.pop_front();
          if (bus.rf_w_adr !== e.adr || bus.rf_W !== e.data ||
              bus.gnt0 !== (e.src == 2'd0) ||
              bus.gnt1 !== (e.src == 2'd1) ||
              bus.init_busy !== (e.src == 2'd2)) begin
            n_fail++;
            $display("FAIL sb_write: got adr=%0d W=%h g0=%b g1=%b ib=%b, required adr=%0d W=%h src=%0d",
                     bus.rf_w_adr, bus.rf_W, bus.gnt0, bus.gnt1,
                     bus.init_busy, e.adr, e.data, e.src);
          end
        end
      end else if (bus.rf_we !== 1'b0 || bus.gnt0 !== 1'b0 ||
                   bus.gnt1 !== 1'b0) begin
        n_fail++;
        $display("FAIL idle: rf_we=%b g0=%b g1=%b required 0/0/0",
                 bus.rf_we, bus.gnt0, bus.gnt1);
      end
    end
  end

  task automatic test_reset;
    reset = 1'b1;
    tick; tick;
    mon_en = 1'b1;
    n_tests++;
    if (bus.rf_we !== 1'b0 || bus.gnt0 !== 1'b0 ||
        bus.gnt1 !== 1'b0 || bus.init_busy !== 1'b1 ||
        bus.rf_w_adr !== 3'd0 || bus.rf_W !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_state: we=%b g0=%b g1=%b ib=%b adr=%0d W=%h required 0 0 0 1 0 0000",
               bus.rf_we, bus.gnt0, bus.gnt1, bus.init_busy,
               bus.rf_w_adr, bus.rf_W);
    end
    push_init;
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick;
      n_tests++;
      if (bus.rf_we !== 1'b1 || bus.rf_w_adr !== 3'(i) ||
          bus.init_busy !== 1'b1) begin
        n_fail++;
        $display("FAIL init_write: we=%b adr=%0d ib=%b required 1 %0d 1",
                 bus.rf_we, bus.rf_w_adr, bus.init_busy, i);
      end
    end
    tick;
    n_tests++;
    if (bus.init_busy !== 1'b0 || bus.rf_we !== 1'b0) begin
      n_fail++;
      $display("FAIL init_done: ib=%b we=%b required 0 0",
               bus.init_busy, bus.rf_we);
    end
  endtask

  task automatic test_single_req0;
    bus.adr0 = 3'd3; bus.data0 = 16'h00A5; bus.req0 = 1'b1;
    repeat (3) push(3'd3, 16'h00A5, 2'd0);
    for (int i = 0; i < 6; i++) begin
      tick;
      n_tests++;
      if (bus.gnt0 !== ((i % 2) == 0)) begin
        n_fail++;
        $display("FAIL single_gnt0: cycle %0d gnt0=%b required %b",
                 i, bus.gnt0, (i % 2) == 0);
      end
    end
    bus.req0 = 1'b0;
    tick; tick;
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL single_drain: %0d left, required 0", sb.size());
    end
  endtask

  task automatic test_back_to_back;
    run_init;
    bus.adr0 = 3'd1; bus.data0 = 16'h1111;
    bus.adr1 = 3'd2; bus.data1 = 16'h2222;
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      push(3'd1, 16'h1111, 2'd0);
      push(3'd2, 16'h2222, 2'd1);
    end
    for (int i = 0; i < 6; i++) begin
      tick;
      n_tests++;
      if (bus.rf_we !== 1'b1 || bus.gnt0 !== ((i % 2) == 0) ||
          bus.gnt1 !== ((i % 2) == 1)) begin
        n_fail++;
        $display("FAIL b2b_alt: cycle %0d we=%b g0=%b g1=%b required 1 %b %b",
                 i, bus.rf_we, bus.gnt0, bus.gnt1,
                 (i % 2) == 0, (i % 2) == 1);
      end
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    tick; tick;
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL b2b_drain: %0d left, required 0", sb.size());
    end
  endtask

  task automatic test_req1_in_init;
    reset = 1'b1;
    bus.adr1 = 3'd5; bus.data1 = 16'hBEEF; bus.req1 = 1'b1;
    tick;
    push_init;
    push(3'd5, 16'hBEEF, 2'd1);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick;
      n_tests++;
      if (bus.gnt1 !== 1'b0) begin
        n_fail++;
        $display("FAIL init_no_gnt1: cycle %0d gnt1=%b required 0",
                 i, bus.gnt1);
      end
    end
    tick;
    n_tests++;
    if (bus.gnt1 !== 1'b1 || bus.rf_w_adr !== 3'd5 ||
        bus.rf_W !== 16'hBEEF) begin
      n_fail++;
      $display("FAIL first_run_gnt1: g1=%b adr=%0d W=%h required 1 5 beef",
               bus.gnt1, bus.rf_w_adr, bus.rf_W);
    end
    bus.req1 = 1'b0;
    tick; tick;
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL req1_drain: %0d left, required 0", sb.size());
    end
  endtask

  task automatic test_reset_mid_init;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) push(3'(i), 16'h0000, 2'd2);
    repeat (3) tick;
    reset = 1'b1;
    tick;
    n_tests++;
    if (bus.rf_we !== 1'b0 || bus.init_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_init_reset: we=%b ib=%b required 0 1",
               bus.rf_we, bus.init_busy);
    end
    reset = 1'b0;
    push_init;
    for (int i = 0; i < 8; i++) begin
      tick;
      n_tests++;
      if (bus.rf_we !== 1'b1 || bus.rf_w_adr !== 3'(i)) begin
        n_fail++;
        $display("FAIL restart_write: we=%b adr=%0d required 1 %0d",
                 bus.rf_we, bus.rf_w_adr, i);
      end
    end
    tick;
    n_tests++;
    if (bus.init_busy !== 1'b0 || sb.size() != 0) begin
      n_fail++;
      $display("FAIL restart_done: ib=%b left=%0d required 0 0",
               bus.init_busy, sb.size());
    end
  endtask

  task automatic test_reset_in_run;
    bus.adr0 = 3'd4; bus.data0 = 16'h0444;
    bus.adr1 = 3'd6; bus.data1 = 16'h0666;
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    push(3'd4, 16'h0444, 2'd0);
    push(3'd6, 16'h0666, 2'd1);
    push(3'd4, 16'h0444, 2'd0);
    repeat (3) tick;
    reset = 1'b1;
    tick;
    n_tests++;
    if (bus.rf_we !== 1'b0 || bus.gnt0 !== 1'b0 ||
        bus.gnt1 !== 1'b0 || bus.init_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL run_reset: we=%b g0=%b g1=%b ib=%b required 0 0 0 1",
               bus.rf_we, bus.gnt0, bus.gnt1, bus.init_busy);
    end
    reset = 1'b0;
    push_init;
    push(3'd4, 16'h0444, 2'd0);
    push(3'd6, 16'h0666, 2'd1);
    for (int i = 0; i < 8; i++) begin
      tick;
      n_tests++;
      if (bus.gnt0 !== 1'b0 || bus.gnt1 !== 1'b0) begin
        n_fail++;
        $display("FAIL reinit_no_gnt: g0=%b g1=%b required 0 0",
                 bus.gnt0, bus.gnt1);
      end
    end
    tick;
    n_tests++;
    if (bus.gnt0 !== 1'b1) begin
      n_fail++;
      $display("FAIL rr_restart0: gnt0=%b required 1", bus.gnt0);
    end
    tick;
    n_tests++;
    if (bus.gnt1 !== 1'b1) begin
      n_fail++;
      $display("FAIL rr_restart1: gnt1=%b required 1", bus.gnt1);
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    tick; tick;
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL run_reset_drain: %0d left, required 0", sb.size());
    end
  endtask

  initial begin
    bus.req0 = 1'b0; bus.adr0 = '0; bus.data0 = '0;
    bus.req1 = 1'b0; bus.adr1 = '0; bus.data1 = '0;
    test_reset;
    test_single_req0;
    test_back_to_back;
    test_req1_in_init;
    test_reset_mid_init;
    test_reset_in_run;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
